array_ctrl_16: RTL and testbench
================================

Name: array_ctrl_16

Overview:
Sequencer for the 16x16 unary-rate systolic MAC array. It runs one tile per start command, in this order: clear, weight load, streaming of N input vectors (each MAC lasts a programmable number of unary cycles), pipeline flush, then output drain. It generates every row and column control strobe the array consumes, including the per-row systolic skew, and it issues read pulses to the ifm and weight buffers.

Parameters:
HEIGHT, 16, array rows; length of the row-skew pipelines.
WIDTH, 16, array columns; used in the flush count.
CYC_W, 8, width of the per-MAC unary cycle count.
VEC_W, 16, width of the input-vector count.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  tile start pulse; accepted only in IDLE
cfg_mac_cycles  in  CYC_W  unary cycles per MAC; 0 is treated as 1
cfg_num_vec  in  VEC_W  input vectors per tile; 0 is treated as 1
busy  out  1  high from the cycle after start is accepted through the DONE cycle
done  out  1  one-cycle pulse at the end of the tile
wght_rd  out  1  weight-buffer read strobe, one per load cycle
ifm_rd  out  1  ifm-buffer read strobe, pulsed on the first cycle of each vector
en_i  out  HEIGHT  per-row input enable (skewed)
clr_i  out  HEIGHT  per-row input clear (skewed)
mac_done  out  HEIGHT  per-row MAC-complete strobe (skewed)
en_w  out  WIDTH  per-column weight shift enable
clr_w  out  WIDTH  per-column weight clear
en_o  out  WIDTH  per-column output shift enable
clr_o  out  WIDTH  per-column output clear
ofm_vld  out  1  output word valid at the bottom of the array; equals en_o[0]

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Output timing: all outputs are registered. Reset value of every output is 0. Reset also clears the FSM, all counters, the latched configuration and the skew pipelines.
- Reset mid-operation: the tile is abandoned. The next cycle is IDLE with all strobes 0. No done pulse is issued.
- Start acceptance: start is sampled only in IDLE. cfg_mac_cycles and cfg_num_vec are latched on the accepting edge, with zero values replaced by 1. A start pulse outside IDLE is ignored.
- Base strobes: the FSM drives base row strobes b_en_i, b_clr_i and b_mac_done. Row 0 outputs equal the base strobes. Row h output equals the base strobe delayed h cycles through a registered shift chain.
- Column strobes: en_w, clr_w, en_o and clr_o are unskewed; all columns carry the same value.
- FSM states and transitions:
  - IDLE: busy=0. On start, go to CLR.
  - CLR (1 cycle): clr_w, clr_o and b_clr_i are all 1. Go to LOAD.
  - LOAD (HEIGHT cycles): en_w=1 and wght_rd=1. Go to COMP.
  - COMP (mac_cycles x num_vec cycles), tracked by a cycle counter c and a vector counter v:
    - b_en_i=1 on every cycle.
    - ifm_rd=1 when c=0.
    - b_mac_done=1 when c=mac_cycles-1; then c wraps to 0 and v increments.
    - After the last cycle of vector num_vec-1, go to FLUSH.
  - FLUSH (HEIGHT+WIDTH-2 cycles): no strobes. This lets the row skew and the in-row propagation of mac_done reach PE[HEIGHT-1][WIDTH-1]. Go to DRAIN.
  - DRAIN (HEIGHT cycles): en_o=1 and ofm_vld=1. Go to DONE.
  - DONE (1 cycle): done=1. Go to IDLE.
- busy: 1 in every state except IDLE.
- Skew pipelines: they keep shifting in every state. Trailing skewed strobes from COMP continue during FLUSH, and they are fully drained before DRAIN begins.
- mac_cycles=1: every COMP cycle has b_en_i, b_mac_done and ifm_rd all equal to 1.
- Counter widths: counters are sized to exactly CYC_W and VEC_W. Maximum values (2^CYC_W-1, 2^VEC_W-1) must complete without wrap error.
- Total tile length from the accepting edge to done: 1 + H + M·N + (H+W-2) + H + 1 cycles, where M = mac_cycles, N = num_vec, H = HEIGHT and W = WIDTH.

Test Plan:
1. Reset, then idle for 5 cycles -> all outputs 0, busy=0.
2. start with cfg_mac_cycles=4, cfg_num_vec=2, where the accepting edge is cycle 0. Required response:
   - cycle 1: clr_w, clr_o and clr_i[0] are 1; clr_i[15] is 1 at cycle 16.
   - cycles 2-17: en_w=1 and wght_rd=1.
   - cycles 18-25: en_i[0]=1; ifm_rd at cycles 18 and 22; mac_done[0] at cycles 21 and 25.
   - en_i[15] is 1 during cycles 33-40; mac_done[15] at cycles 36 and 40.
   - cycles 56-71: en_o=1 and ofm_vld=1.
   - cycle 72: done=1. Cycle 73: busy=0.
3. cfg_mac_cycles=0, cfg_num_vec=0 -> behaves as 1/1: COMP lasts exactly 1 cycle with en_i[0], mac_done[0] and ifm_rd all 1; done arrives at cycle 65.
4. start re-pulsed during COMP, and again during DRAIN -> ignored; the timing of test 2 is unchanged and only one done pulse is issued.
5. rst asserted at cycle 20 of test 2 -> at cycle 21 all outputs are 0, including the skewed en_i[15:1]. A new start after reset runs test 2 timing exactly.
6. Back-to-back: start asserted in the cycle right after done -> accepted, and the second tile matches test 2 timing offset by 74 cycles.

Source files
------------

// File: rtl/array_ctrl_16.sv
// Tile sequencer for the 16x16 unary-rate systolic MAC array.
// Runs clear, weight load, compute, flush and drain, and skews the row strobes.
module array_ctrl_16 #(
    parameter int HEIGHT = 16,
    parameter int WIDTH  = 16,
    parameter int CYC_W  = 8,
    parameter int VEC_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CYC_W-1:0]  cfg_mac_cycles,
    input  logic [VEC_W-1:0]  cfg_num_vec,
    output logic              busy,
    output logic              done,
    output logic              wght_rd,
    output logic              ifm_rd,
    output logic [HEIGHT-1:0] en_i,
    output logic [HEIGHT-1:0] clr_i,
    output logic [HEIGHT-1:0] mac_done,
    output logic [WIDTH-1:0]  en_w,
    output logic [WIDTH-1:0]  clr_w,
    output logic [WIDTH-1:0]  en_o,
    output logic [WIDTH-1:0]  clr_o,
    output logic              ofm_vld
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_LOAD, S_COMP, S_FLUSH, S_DRAIN, S_DONE
    } state_t;

    localparam int CNT_W = $clog2(HEIGHT + WIDTH);
    localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(HEIGHT - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(HEIGHT + WIDTH - 3);

    state_t            state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic [CYC_W-1:0]  mac_cycles, c;
    logic [VEC_W-1:0]  num_vec, v;

    logic b_clr, b_load, b_en_i, b_ifm, b_mac_done, b_drain, b_done;

    always_comb begin
        next_state = state;
        b_clr      = 1'b0;
        b_load     = 1'b0;
        b_en_i     = 1'b0;
        b_ifm      = 1'b0;
        b_mac_done = 1'b0;
        b_drain    = 1'b0;
        b_done     = 1'b0;
        case (state)
            S_IDLE:  if (start) next_state = S_CLR;
            S_CLR: begin
                b_clr      = 1'b1;
                next_state = S_LOAD;
            end
            S_LOAD: begin
                b_load = 1'b1;
                if (cnt == ROW_LAST) next_state = S_COMP;
            end
            S_COMP: begin
                b_en_i     = 1'b1;
                b_ifm      = (c == '0);
                b_mac_done = (c == mac_cycles - CYC_W'(1));
                if (b_mac_done && (v == num_vec - VEC_W'(1))) next_state = S_FLUSH;
            end
            S_FLUSH: if (cnt == FLUSH_LAST) next_state = S_DRAIN;
            S_DRAIN: begin
                b_drain = 1'b1;
                if (cnt == ROW_LAST) next_state = S_DONE;
            end
            S_DONE: begin
                b_done     = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            c          <= '0;
            v          <= '0;
            mac_cycles <= '0;
            num_vec    <= '0;
        end else begin
            state <= next_state;
            if (next_state != state)
                cnt <= '0;
            else if (state inside {S_LOAD, S_FLUSH, S_DRAIN})
                cnt <= cnt + CNT_W'(1);

            if (state == S_IDLE && start) begin
                mac_cycles <= (cfg_mac_cycles == '0) ? CYC_W'(1) : cfg_mac_cycles;
                num_vec    <= (cfg_num_vec == '0) ? VEC_W'(1) : cfg_num_vec;
            end

            if (state == S_CLR) begin
                c <= '0;
                v <= '0;
            end else if (state == S_COMP) begin
                if (b_mac_done) begin
                    c <= '0;
                    v <= v + VEC_W'(1);
                end else begin
                    c <= c + CYC_W'(1);
                end
            end
        end
    end

    // Row 0 is the registered base strobe; row h is the same strobe h cycles later.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            wght_rd  <= 1'b0;
            ifm_rd   <= 1'b0;
            ofm_vld  <= 1'b0;
            en_i     <= '0;
            clr_i    <= '0;
            mac_done <= '0;
            en_w     <= '0;
            clr_w    <= '0;
            en_o     <= '0;
            clr_o    <= '0;
        end else begin
            busy     <= (state != S_IDLE);
            done     <= b_done;
            wght_rd  <= b_load;
            ifm_rd   <= b_ifm;
            ofm_vld  <= b_drain;
            en_i     <= {en_i[HEIGHT-2:0], b_en_i};
            clr_i    <= {clr_i[HEIGHT-2:0], b_clr};
            mac_done <= {mac_done[HEIGHT-2:0], b_mac_done};
            en_w     <= {WIDTH{b_load}};
            clr_w    <= {WIDTH{b_clr}};
            en_o     <= {WIDTH{b_drain}};
            clr_o    <= {WIDTH{b_clr}};
        end
    end

endmodule

// File: tb/tb_array_ctrl_16.sv
// Bench for array_ctrl_16: every output is compared each cycle against a
// timeline computed arithmetically from the tile phase lengths.
module tb_array_ctrl_16;

    localparam int H = 16;
    localparam int W = 16;
    localparam int OW = 5 + 3 * H + 4 * W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   cfg_mac_cycles = '0;
    logic [15:0]  cfg_num_vec = '0;
    logic         busy, done, wght_rd, ifm_rd, ofm_vld;
    logic [H-1:0] en_i, clr_i, mac_done;
    logic [W-1:0] en_w, clr_w, en_o, clr_o;
    logic [OW-1:0] obs, exp_v;

    int tests = 0;
    int fails = 0;

    array_ctrl_16 #(.HEIGHT(H), .WIDTH(W), .CYC_W(8), .VEC_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_mac_cycles(cfg_mac_cycles), .cfg_num_vec(cfg_num_vec),
        .busy(busy), .done(done), .wght_rd(wght_rd), .ifm_rd(ifm_rd),
        .en_i(en_i), .clr_i(clr_i), .mac_done(mac_done),
        .en_w(en_w), .clr_w(clr_w), .en_o(en_o), .clr_o(clr_o),
        .ofm_vld(ofm_vld)
    );

    always #5 clk = ~clk;

    assign obs = {busy, done, wght_rd, ifm_rd, ofm_vld, en_i, clr_i, mac_done,
                  en_w, clr_w, en_o, clr_o};

    function automatic int eff(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    function automatic int done_time(input int m, input int n);
        return 1 + H + eff(m) * eff(n) + (H + W - 2) + H + 1;
    endfunction

    // Expected outputs t cycles after the accepting edge of a tile.
    function automatic logic [OW-1:0] model(input int t, input int m, input int n);
        int mm, s_comp, e_comp, s_drain, t_done, tr;
        logic [H-1:0] ei, ci, md;
        logic in_comp, ld, dr;
        mm = eff(m);
        s_comp  = 2 + H;
        e_comp  = s_comp + mm * eff(n);
        s_drain = e_comp + H + W - 2;
        t_done  = s_drain + H;
        for (int h = 0; h < H; h++) begin
            tr = t - h;
            ci[h] = (tr == 1);
            ei[h] = (tr >= s_comp) && (tr < e_comp);
            md[h] = ei[h] && (((tr - s_comp) % mm) == mm - 1);
        end
        in_comp = (t >= s_comp) && (t < e_comp);
        ld = (t >= 2) && (t < s_comp);
        dr = (t >= s_drain) && (t < t_done);
        return {(t >= 1) && (t <= t_done), t == t_done, ld,
                in_comp && (((t - s_comp) % mm) == 0), dr,
                ei, ci, md, {W{ld}}, {W{t == 1}}, {W{dr}}, {W{t == 1}}};
    endfunction

    task automatic start_tile(input int m, input int n);
        cfg_mac_cycles = 8'(m);
        cfg_num_vec    = 16'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++;
            if (obs !== '0) begin
                fails++;
                $display("FAIL reset_idle cyc=%0d got=%h want=0", i, obs);
            end
        end
    endtask

    task automatic test_basic();
        start_tile(4, 2);
        for (int t = 0; t <= 75; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            exp_v = model(t, 4, 2);
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL basic t=%0d got=%h want=%h", t, obs, exp_v);
            end
        end
    endtask

    task automatic test_zero_cfg();
        start_tile(0, 0);
        for (int t = 0; t <= 67; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            exp_v = model(t, 0, 0);
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL zero_cfg t=%0d got=%h want=%h", t, obs, exp_v);
            end
        end
    endtask

    task automatic test_restart_ignored();
        int dones = 0;
        start_tile(4, 2);
        for (int t = 0; t <= 75; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            start = 1'b0;
            exp_v = model(t, 4, 2);
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL restart t=%0d got=%h want=%h", t, obs, exp_v);
            end
            if (done) dones++;
            if (t == 20 || t == 60) start = 1'b1;
        end
        tests++;
        if (dones != 1) begin
            fails++;
            $display("FAIL restart_done_count got=%0d want=1", dones);
        end
    endtask

    task automatic test_mid_reset();
        start_tile(4, 2);
        for (int t = 0; t <= 22; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            rst = 1'b0;
            exp_v = (t <= 20) ? model(t, 4, 2) : '0;
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL mid_reset t=%0d got=%h want=%h", t, obs, exp_v);
            end
            if (t == 20) rst = 1'b1;
        end
        start_tile(4, 2);
        for (int t = 0; t <= 75; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            exp_v = model(t, 4, 2);
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL after_reset t=%0d got=%h want=%h", t, obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        start_tile(4, 2);
        for (int t = 0; t <= 150; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            start = 1'b0;
            exp_v = (t < 74) ? model(t, 4, 2) : model(t - 74, 4, 2);
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL back_to_back t=%0d got=%h want=%h", t, obs, exp_v);
            end
            if (t == 73) start = 1'b1;
        end
    endtask

    // Random configurations; cfg inputs are scrambled mid-tile to prove they are latched.
    task automatic test_random();
        int m, n, len;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                m = 255;
                n = 2;
            end else begin
                m = $urandom_range(0, 7);
                n = $urandom_range(0, 5);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            start_tile(m, n);
            len = done_time(m, n) + 2;
            for (int t = 0; t <= len; t++) begin
                if (t > 0) begin @(posedge clk); #1; end
                exp_v = model(t, m, n);
                tests++;
                if (obs !== exp_v) begin
                    fails++;
                    $display("FAIL random m=%0d n=%0d t=%0d got=%h want=%h",
                             m, n, t, obs, exp_v);
                end
                cfg_mac_cycles = 8'($urandom);
                cfg_num_vec    = 16'($urandom);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_cfg();
        test_restart_ignored();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
